// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer for a single-port data memory.
// One transaction at a time: IDLE arbitrates, ISSUE drives the memory, RESP returns read data.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic              last_owner_reg, last_owner_next;
  logic              txn_we_reg, txn_we_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        rvalid_reg, rvalid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              busy_reg, busy_next;
  logic              mem_re_reg, mem_re_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

  logic [1:0]        req_vec;
  logic [1:0]        lock_vec;
  logic [1:0]        we_vec;
  logic [1:0]        wins;
  logic [ADDR_W-1:0] addr_vec [2];
  logic [DATA_W-1:0] wdata_vec [2];
  logic              winner;

  assign req_vec      = {req1, req0};
  assign lock_vec     = {lock1, lock0};
  assign we_vec       = {we1, we0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  // A requester wins alone, or on a tie when it is the locked last owner or
  // when the last owner is someone else and not holding its lock.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_vote
      localparam bit ME = (gi == 1);
      assign wins[gi] = req_vec[gi] &
                        (~req_vec[1-gi] |
                         ((last_owner_reg == ME) ? lock_vec[gi] : ~lock_vec[1-gi]));
    end
  endgenerate

  assign winner = wins[1];

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    txn_we_next     = txn_we_reg;
    gnt_next        = '0;
    rvalid_next     = '0;
    rdata_next      = rdata_reg;
    mem_re_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    busy_next       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (|wins) begin
          state_next       = ISSUE;
          last_owner_next  = winner;
          txn_we_next      = we_vec[winner];
          gnt_next[winner] = 1'b1;
          mem_we_next      = we_vec[winner];
          mem_re_next      = ~we_vec[winner];
          mem_addr_next    = addr_vec[winner];
          mem_wdata_next   = wdata_vec[winner];
        end
      end
      ISSUE: begin
        // Memory samples at the edge ending this cycle; writes need no response.
        state_next = txn_we_reg ? IDLE : RESP;
      end
      RESP: begin
        state_next                  = IDLE;
        rdata_next                  = mem_rdata;
        rvalid_next[last_owner_reg] = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      txn_we_reg     <= 1'b0;
      gnt_reg        <= '0;
      rvalid_reg     <= '0;
      rdata_reg      <= '0;
      busy_reg       <= 1'b0;
      mem_re_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      txn_we_reg     <= txn_we_next;
      gnt_reg        <= gnt_next;
      rvalid_reg     <= rvalid_next;
      rdata_reg      <= rdata_next;
      busy_reg       <= busy_next;
      mem_re_reg     <= mem_re_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign rvalid0   = rvalid_reg[0];
  assign rvalid1   = rvalid_reg[1];
  assign rdata     = rdata_reg;
  assign busy      = busy_reg;
  assign mem_re    = mem_re_reg;
  assign mem_we    = mem_we_reg;
  assign mem_raddr = mem_addr_reg;
  assign mem_waddr = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
